// File: rtl/mac_pkg.sv
`default_nettype none
// =============================================================================
// mac_pkg : shared defaults, output-width function and result type for mac_acc_n
// Rev 1.0
// =============================================================================
package mac_pkg;

   localparam int C_LANES_DEF   = 16;
   localparam int C_DW_DEF      = 8;
   localparam int C_ACC_LEN_DEF = 4;
   localparam int C_BW_DEF      = 8;

   // Product of unsigned DW by signed DW needs 2*DW+1; growth covers lanes, beats and bias.
   function automatic int ow_f(input int lanes, input int dw, input int acc_len);
      return 2 * dw + 1 + $clog2(lanes) + $clog2(acc_len) + 1;
   endfunction

   localparam int C_OW_DEF = ow_f(C_LANES_DEF, C_DW_DEF, C_ACC_LEN_DEF);

   typedef logic signed [C_OW_DEF-1:0] result_t;

endpackage
`default_nettype wire

// File: rtl/mac_lane_tree.sv
`default_nettype none
// =============================================================================
// mac_lane_tree : LANES unsigned-by-signed multipliers, adder tree, one output register
// Rev 1.0
// =============================================================================
module mac_lane_tree
   import mac_pkg::*;
#(
   parameter int LANES = C_LANES_DEF,
   parameter int DW    = C_DW_DEF,
   parameter int SW    = C_OW_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en_i,
   input  logic [LANES*DW-1:0]        p_i,
   input  logic [LANES*DW-1:0]        w_i,
   output logic signed [SW-1:0]       sum_o
);
   localparam int PW = 2 * DW + 1;

   logic signed [PW-1:0] prod_w [LANES];
   logic signed [SW-1:0] tree_w;
   logic signed [SW-1:0] sum_q;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic signed [DW:0]   p_ext_w;
      logic signed [DW-1:0] w_s_w;
      assign p_ext_w   = {1'b0, p_i[i*DW +: DW]};
      assign w_s_w     = w_i[i*DW +: DW];
      assign prod_w[i] = PW'(p_ext_w) * PW'(w_s_w);
   end

   always_comb begin
      tree_w = '0;
      for (int i = 0; i < LANES; i++) begin
         tree_w = tree_w + SW'(prod_w[i]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sum_q <= '0;
      end else if (en_i) begin
         sum_q <= tree_w;
      end
   end

   assign sum_o = sum_q;

endmodule
`default_nettype wire

// File: rtl/mac_acc_n.sv
`default_nettype none
// =============================================================================
// mac_acc_n : 3-stage lane MAC, accumulates ACC_LEN beats plus bias per result.
// Option RELU_EN clamps negative results to zero.  Rev 1.0
// =============================================================================
module mac_acc_n
   import mac_pkg::*;
#(
   parameter int  LANES   = C_LANES_DEF,
   parameter int  DW      = C_DW_DEF,
   parameter int  ACC_LEN = C_ACC_LEN_DEF,
   parameter int  BW      = C_BW_DEF,
   localparam int OW      = ow_f(LANES, DW, ACC_LEN)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic [LANES*DW-1:0]        p,
   input  logic [LANES*DW-1:0]        w,
   input  logic signed [BW-1:0]       b,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic signed [OW-1:0]       dout,
   output logic signed [OW-1:0]       sum_out
);
   localparam int            CW     = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(ACC_LEN - 1);

   logic                 stall_w;
   logic                 accept_w;
   logic                 first_w;
   logic                 last_w;
   logic signed [OW-1:0] sum3_w;

   logic [CW-1:0]        cnt_q,       cnt_d;
   logic                 s1_vld_q,    s1_vld_d;
   logic                 s1_first_q,  s1_first_d;
   logic                 s1_last_q,   s1_last_d;
   logic signed [BW-1:0] s1_b_q,      s1_b_d;
   logic signed [OW-1:0] acc_q,       acc_d;
   logic                 s2_done_q,   s2_done_d;
   logic signed [BW-1:0] s2_b_q,      s2_b_d;
   logic signed [OW-1:0] dout_q,      dout_d;
   logic                 out_valid_q, out_valid_d;

   assign stall_w  = out_valid_q && !out_ready;
   assign in_ready = !stall_w;
   assign accept_w = in_valid && in_ready && !clr;
   assign first_w  = (cnt_q == '0);
   assign last_w   = (cnt_q == C_LAST);
   assign sum3_w   = acc_q + OW'(s2_b_q);

   mac_lane_tree #(
      .LANES (LANES),
      .DW    (DW),
      .SW    (OW)
   ) u_tree (
      .clk   (clk),
      .rst   (rst),
      .en_i  (accept_w),
      .p_i   (p),
      .w_i   (w),
      .sum_o (sum_out)
   );

   always_comb begin
      cnt_d       = cnt_q;
      s1_vld_d    = s1_vld_q;
      s1_first_d  = s1_first_q;
      s1_last_d   = s1_last_q;
      s1_b_d      = s1_b_q;
      acc_d       = acc_q;
      s2_done_d   = s2_done_q;
      s2_b_d      = s2_b_q;
      dout_d      = dout_q;
      out_valid_d = out_valid_q;

      // Abort drops everything upstream of the output register, even when stalled.
      if (clr) begin
         cnt_d     = '0;
         s1_vld_d  = 1'b0;
         s2_done_d = 1'b0;
      end else if (!stall_w) begin
         if (accept_w) begin
            cnt_d      = last_w ? '0 : cnt_q + CW'(1);
            s1_first_d = first_w;
            s1_last_d  = last_w;
            s1_b_d     = b;
         end
         s1_vld_d = accept_w;
         if (s1_vld_q) begin
            acc_d = s1_first_q ? sum_out : acc_q + sum_out;
         end
         s2_done_d = s1_vld_q && s1_last_q;
         s2_b_d    = s1_b_q;
      end

      if (!stall_w) begin
         out_valid_d = s2_done_q && !clr;
         if (s2_done_q && !clr) begin
`ifdef RELU_EN
            dout_d = sum3_w[OW-1] ? '0 : sum3_w;
`else
            dout_d = sum3_w;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q       <= '0;
         s1_vld_q    <= 1'b0;
         s1_first_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         s1_b_q      <= '0;
         acc_q       <= '0;
         s2_done_q   <= 1'b0;
         s2_b_q      <= '0;
         dout_q      <= '0;
         out_valid_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         s1_vld_q    <= s1_vld_d;
         s1_first_q  <= s1_first_d;
         s1_last_q   <= s1_last_d;
         s1_b_q      <= s1_b_d;
         acc_q       <= acc_d;
         s2_done_q   <= s2_done_d;
         s2_b_q      <= s2_b_d;
         dout_q      <= dout_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign dout      = dout_q;
   assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_acc_n.sv
`default_nettype none
// =============================================================================
// tb_mac_acc_n : scoreboard bench for mac_acc_n (honours RELU_EN in its model)
// Rev 1.0
// =============================================================================
module tb_mac_acc_n;
   import mac_pkg::*;

   localparam int LANES   = 16;
   localparam int DW      = 8;
   localparam int ACC_LEN = 4;
   localparam int NB      = LANES * DW;

   logic              clk       = 1'b0;
   logic              rst       = 1'b0;
   logic              clr       = 1'b0;
   logic              in_valid  = 1'b0;
   logic              out_ready = 1'b0;
   logic [NB-1:0]     p         = '0;
   logic [NB-1:0]     w         = '0;
   logic signed [7:0] b         = '0;
   logic              in_ready;
   logic              out_valid;
   result_t           dout;
   result_t           sum_out;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int exp_q[$];
   int res_cyc[$];

   int m_cnt = 0;
   int m_acc = 0;
   bit pend_chk = 1'b0;
   int pend_sum = 0;
   int last_acc_cyc = 0;

   logic [NB-1:0] ones  = {LANES{8'h01}};
   logic [NB-1:0] allff = '1;

   mac_acc_n #(
      .LANES   (LANES),
      .DW      (DW),
      .ACC_LEN (ACC_LEN),
      .BW      (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .p         (p),
      .w         (w),
      .b         (b),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dout      (dout),
      .sum_out   (sum_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: dot product of unsigned pixels and signed weights.
   function automatic int beat_sum(input logic [NB-1:0] pv, input logic [NB-1:0] wv);
      int                s;
      logic [7:0]        pe;
      logic signed [7:0] we;
      s = 0;
      for (int i = 0; i < LANES; i++) begin
         pe = pv[i*DW +: DW];
         we = wv[i*DW +: DW];
         s  = s + int'(pe) * int'(we);
      end
      return s;
   endfunction

   task automatic model_beat(input int s, input logic signed [7:0] bv);
      int r;
      m_acc = m_acc + s;
      m_cnt++;
      if (m_cnt == ACC_LEN) begin
         r = m_acc + int'(bv);
`ifdef RELU_EN
         if (r < 0) r = 0;
`endif
         exp_q.push_back(r);
         m_cnt = 0;
         m_acc = 0;
      end
   endtask

   function automatic logic [NB-1:0] rvec();
      logic [NB-1:0] v;
      for (int i = 0; i < NB / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic beat(input bit v, input logic [NB-1:0] pv, input logic [NB-1:0] wv,
                       input logic signed [7:0] bv, input bit c, input bit ordy);
      bit acc_now;
      @(posedge clk);
      #1;
      in_valid = v; p = pv; w = wv; b = bv; clr = c; out_ready = ordy;
      @(negedge clk);
      if (pend_chk) check("sum_out", int'(sum_out), pend_sum);
      pend_chk = 1'b0;
      acc_now  = v && in_ready && !c;
      if (c) begin
         m_cnt = 0;
         m_acc = 0;
      end
      if (acc_now) begin
         pend_chk     = 1'b1;
         pend_sum     = beat_sum(pv, wv);
         last_acc_cyc = cyc;
         model_beat(pend_sum, bv);
      end
   endtask

   task automatic idle(input int n, input bit ordy);
      for (int k = 0; k < n; k++) beat(1'b0, '0, '0, 8'sd0, 1'b0, ordy);
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 60) begin
         idle(1, 1'b1);
         k++;
      end
      check("drain_pending", exp_q.size(), 0);
      idle(1, 1'b1);
   endtask

   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         res_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL dout_unexpected: got %0d expected no result", int'(dout));
         end else begin
            check("dout", int'(dout), exp_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic signed [7:0] rb;

      repeat (3) @(posedge clk);
      #1;
      check("rst_dout", int'(dout), 0);
      check("rst_sum_out", int'(sum_out), 0);
      check("rst_out_valid", int'(out_valid), 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("in_ready_after_rst", int'(in_ready), 1);

      // Unity group with latency measurement
      res_cyc.delete();
      for (int k = 0; k < 4; k++) beat(1'b1, ones, ones, 8'sd11, 1'b0, 1'b1);
      drain();
      check("unity_latency", (res_cyc.size() > 0) ? res_cyc[0] - last_acc_cyc : -1, 3);

      // All-negative products
      for (int k = 0; k < 4; k++) beat(1'b1, allff, allff, 8'sd0, 1'b0, 1'b1);
      drain();

      // Back-pressure: result held five cycles with a beat offered each cycle
      for (int k = 0; k < 4; k++) beat(1'b1, ones, ones, 8'sd11, 1'b0, 1'b0);
      idle(2, 1'b0);
      for (int k = 0; k < 5; k++) begin
         beat(1'b1, rvec(), rvec(), 8'sd3, 1'b0, 1'b0);
         check("bp_in_ready", int'(in_ready), 0);
         check("bp_out_valid", int'(out_valid), 1);
         check("bp_dout", int'(dout), 75);
      end
      for (int k = 0; k < 4; k++) begin
         rb = 8'($urandom);
         beat(1'b1, rvec(), rvec(), rb, 1'b0, 1'b1);
      end
      drain();

      // Abort after two beats
      for (int k = 0; k < 2; k++) beat(1'b1, rvec(), rvec(), 8'sd7, 1'b0, 1'b1);
      beat(1'b1, rvec(), rvec(), 8'sd7, 1'b1, 1'b1);
      for (int k = 0; k < 4; k++) beat(1'b1, ones, ones, 8'sd0, 1'b0, 1'b1);
      drain();

      // Asynchronous reset with a stalled result and a partial group in flight
      for (int k = 0; k < 6; k++) beat(1'b1, ones, ones, 8'sd5, 1'b0, 1'b0);
      idle(1, 1'b0);
      check("pre_rst_out_valid", int'(out_valid), 1);
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check("arst_dout", int'(dout), 0);
      check("arst_sum_out", int'(sum_out), 0);
      check("arst_out_valid", int'(out_valid), 0);
      exp_q.delete();
      m_cnt = 0;
      m_acc = 0;
      pend_chk = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 4; k++) beat(1'b1, ones, ones, 8'sd0, 1'b0, 1'b1);
      drain();

      // Streaming: ten back-to-back groups
      res_cyc.delete();
      for (int g = 0; g < 10; g++) begin
         for (int k = 0; k < 4; k++) begin
            rb = 8'($urandom);
            beat(1'b1, rvec(), rvec(), rb, 1'b0, 1'b1);
         end
      end
      drain();
      check("stream_count", res_cyc.size(), 10);
      for (int i = 1; i < res_cyc.size(); i++) begin
         check("stream_spacing", res_cyc[i] - res_cyc[i-1], 4);
      end

      // Random traffic with random gaps and back-pressure
      for (int k = 0; k < 300; k++) begin
         rb = 8'($urandom);
         beat(($urandom % 4) != 0, rvec(), rvec(), rb, 1'b0, ($urandom % 4) != 0);
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mac_acc_n.md
MAC_ACC_N -- requirements
Module: mac_acc_n

Interface
REQ-001 Parameter LANES, default 16: number of pixel/weight lanes per beat.
REQ-002 Parameter DW, default 8: bits per lane for p and w.
REQ-003 Parameter ACC_LEN, default 4: beats accumulated per result, legal range 1..256.
REQ-004 Parameter BW, default 8: bias width.
REQ-005 Derived localparam OW = 2*DW+1 + clog2(LANES) + clog2(ACC_LEN) + 1, which is 24 at the defaults.
REQ-006 clk, input, 1: sole clock; all state updates on its rising edge.
REQ-007 rst, input, 1: asynchronous, active-low reset.
REQ-008 clr, input, 1: synchronous abort of the partial group.
REQ-009 p, input, LANES*DW: unsigned pixels; lane i is p[i*DW +: DW].
REQ-010 w, input, LANES*DW: two's-complement weights, same lane mapping as p.
REQ-011 b, input, BW: signed bias, sampled on the beat that completes a group.
REQ-012 in_valid, input, 1 / in_ready, output, 1: input handshake.
REQ-013 out_valid, output, 1 / out_ready, input, 1: output handshake.
REQ-014 dout, output, OW: signed result.
REQ-015 sum_out, output, OW: registered per-beat lane sum, for debug tap.

Function
REQ-016 A beat is accepted when in_valid && in_ready.
REQ-017 Stage 1 registers sum_out = sum over i of (p_i * w_i), with p zero-extended and w sign-extended.
REQ-018 Stage 2 accumulates sum_out into acc; the first beat of a group loads acc instead of adding.
REQ-019 Beat counter runs 0..ACC_LEN-1 and wraps to 0 after the last beat; ACC_LEN=1 makes every beat a complete group.
REQ-020 On the group's final beat, stage 3 registers dout = acc_final + sign-extended b and asserts out_valid.
REQ-021 Latency: last beat accepted in cycle t gives out_valid in cycle t+3.
REQ-022 Back-to-back groups sustain one beat per cycle when out_ready=1.
REQ-023 Stall condition: out_valid && !out_ready.
  - in_ready=0.
  - All pipeline registers, dout and the counter hold.
REQ-024 out_valid clears on out_ready, unless a new result lands in the same cycle, in which case it stays 1 with the new dout.
REQ-025 clr=1 behaviour:
  - Counter resets to 0.
  - In-flight beats in stages 1–2 are discarded.
  - The beat presented in that cycle is discarded; clr wins over in_valid.
  - A pending dout/out_valid is unaffected.
REQ-026 Arithmetic is exact: OW guarantees no overflow for any input; no wrap or saturation logic.

Reset
REQ-027 rst=0 asynchronously clears:
  - dout, sum_out, acc and counter to 0.
  - out_valid to 0.
  - Pipeline valid bits to 0.
REQ-028 in_ready=1 from the first edge after rst deasserts.
REQ-029 Reset mid-group discards the partial group; the next accepted beat is beat 0.

Configuration
REQ-030 With RELU_EN defined, a negative dout is replaced by 0 at stage 3; out_valid timing is unchanged.
REQ-031 Without RELU_EN, dout is the signed sum unmodified.

Structure
REQ-032 Package mac_pkg holds:
  - Default LANES/DW/ACC_LEN/BW constants.
  - The OW width function.
  - The signed result typedef.
REQ-033 Sub-module mac_lane_tree implements the LANES multipliers plus adder tree with one output register (stage 1); mac_acc_n instantiates it once.

Verification (LANES=16, DW=8, ACC_LEN=4)
REQ-034 Unity: p=1 and w=1 in all lanes for 4 beats, b=11 -> sum_out=16 per beat, dout=75, out_valid exactly 3 cycles after beat 4.
REQ-035 Negative: p=255, w=0xFF for 4 beats, b=0 -> dout=-16320 without RELU_EN; dout=0 with RELU_EN.
REQ-036 Back-pressure: out_ready=0 for 5 cycles after a result -> in_ready=0, dout and out_valid stable; release -> the next group completes correctly.
REQ-037 clr after 2 beats, then 4 unity beats with b=0 -> dout=64, with no contribution from the aborted beats.
REQ-038 rst pulsed low mid-group -> all outputs 0 immediately; the next 4 unity beats with b=0 give dout=64.
REQ-039 Streaming: 10 consecutive groups with out_ready=1 -> 10 results spaced 4 cycles apart, no dropped beats.
